// File: rtl/bcd_pkg.sv
// Shared definitions for the BCD digit counters: digit type, digit bounds
// and the nibble clamp applied to parallel preset values.
package bcd_pkg;

    // One binary-coded decimal digit.
    typedef logic [3:0] bcd_digit_t;

    localparam bcd_digit_t BCD_MAX = 4'd9;
    localparam bcd_digit_t BCD_MIN = 4'd0;

    // Force any non-decimal nibble (A..F) down to 9 so the count register
    // can never hold an invalid digit.
    function automatic bcd_digit_t bcd_clamp(input logic [3:0] nib);
        bcd_digit_t res;
        if (nib > BCD_MAX) begin
            res = BCD_MAX;
        end else begin
            res = nib;
        end
        return res;
    endfunction

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// One decade of the BCD counter. Purely combinational: given the current
// digit, the step enable, the direction and the carry/borrow from the less
// significant digit, produce the stepped digit and the carry/borrow out.
// Instances chain combinationally so a full ripple resolves in one cycle.
module bcd_digit
    import bcd_pkg::*;
(
    input  logic [3:0] i_value,
    input  logic       i_step_en,
    input  logic       i_dir,
    input  logic       i_cin,
    output logic [3:0] o_next,
    output logic       o_cout
);

    // Step this digit only when the counter steps and the lower digits rolled over.
    always_comb begin
        o_next = i_value;
        o_cout = 1'b0;
        if (i_step_en && i_cin) begin
            if (i_dir) begin
                if (i_value == BCD_MAX) begin
                    o_next = BCD_MIN;
                    o_cout = 1'b1;
                end else begin
                    o_next = i_value + 4'd1;
                    o_cout = 1'b0;
                end
            end else begin
                if (i_value == BCD_MIN) begin
                    o_next = BCD_MAX;
                    o_cout = 1'b1;
                end else begin
                    o_next = i_value - 4'd1;
                    o_cout = 1'b0;
                end
            end
        end else begin
            o_next = i_value;
            o_cout = 1'b0;
        end
    end

endmodule : bcd_digit

// File: rtl/bcd_counter_n.sv
// N-digit BCD up/down counter with saturate or wrap mode, synchronous clear,
// clamped parallel preset, terminal-count pulse and optional compare match.
// Optional feature macro: BCD_COUNTER_MATCH_EN adds match_val / match.
// Priority per cycle: rst (active low) > clr > load > step (run & tick).
module bcd_counter_n
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int WRAP   = 0
) (
    input  logic                  clk_used,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    input  logic                  run,
    input  logic                  tick,
    input  logic                  dir,
`ifdef BCD_COUNTER_MATCH_EN
    input  logic [4*DIGITS-1:0]   match_val,
    output logic                  match,
`endif
    output logic [4*DIGITS-1:0]   count,
    output logic                  at_max,
    output logic                  at_min,
    output logic                  tc
);

    localparam int W = 4 * DIGITS;

    logic [W-1:0]      r_count;
    logic              r_tc;

    logic              w_step;
    logic [DIGITS:0]   w_carry;
    logic [W-1:0]      w_step_val;
    logic [W-1:0]      w_load_clamped;
    logic [DIGITS-1:0] w_dig_max;
    logic [DIGITS-1:0] w_dig_min;
    logic [W-1:0]      w_count_nxt;
    logic              w_tc_nxt;
    logic              w_at_term;

    assign w_step     = run & tick;
    // The least significant digit always sees a carry-in; a carry out of
    // the most significant digit means the step started at the terminal state.
    assign w_carry[0] = 1'b1;
    assign w_at_term  = w_carry[DIGITS];

    genvar k;
    generate
        for (k = 0; k < DIGITS; k++) begin : g_digit
            bcd_digit u_digit (
                .i_value   (r_count[4*k +: 4]),
                .i_step_en (w_step),
                .i_dir     (dir),
                .i_cin     (w_carry[k]),
                .o_next    (w_step_val[4*k +: 4]),
                .o_cout    (w_carry[k+1])
            );
            assign w_dig_max[k] = (r_count[4*k +: 4] == BCD_MAX);
            assign w_dig_min[k] = (r_count[4*k +: 4] == BCD_MIN);
        end
    endgenerate

    // Clamp every preset nibble to a legal decimal digit.
    always_comb begin
        w_load_clamped = {W{1'b0}};
        for (int i = 0; i < DIGITS; i++) begin
            w_load_clamped[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
        end
    end

    // Next count and terminal-count pulse, resolved by clr > load > step priority.
    always_comb begin
        w_count_nxt = r_count;
        w_tc_nxt    = 1'b0;
        if (clr) begin
            w_count_nxt = {W{1'b0}};
            w_tc_nxt    = 1'b0;
        end else if (load) begin
            w_count_nxt = w_load_clamped;
            w_tc_nxt    = 1'b0;
        end else if (w_step) begin
            w_tc_nxt = w_at_term;
            if (w_at_term && (WRAP == 0)) begin
                w_count_nxt = r_count;
            end else begin
                w_count_nxt = w_step_val;
            end
        end else begin
            w_count_nxt = r_count;
            w_tc_nxt    = 1'b0;
        end
    end

    // Count and terminal-count registers with synchronous active-low reset.
    always_ff @(posedge clk_used) begin
        if (!rst) begin
            r_count <= {W{1'b0}};
            r_tc    <= 1'b0;
        end else begin
            r_count <= w_count_nxt;
            r_tc    <= w_tc_nxt;
        end
    end

`ifdef BCD_COUNTER_MATCH_EN
    logic r_match;
    logic w_match_nxt;

    // Pulse only when a load or step lands on match_val; clr and idle cycles never pulse.
    always_comb begin
        w_match_nxt = 1'b0;
        if (!clr && (load || w_step)) begin
            w_match_nxt = (w_count_nxt == match_val);
        end else begin
            w_match_nxt = 1'b0;
        end
    end

    // Compare-match pulse register, cleared by reset.
    always_ff @(posedge clk_used) begin
        if (!rst) begin
            r_match <= 1'b0;
        end else begin
            r_match <= w_match_nxt;
        end
    end

    assign match = r_match;
`endif

    assign count  = r_count;
    assign tc     = r_tc;
    assign at_max = &w_dig_max;
    assign at_min = &w_dig_min;

endmodule : bcd_counter_n

// File: tb/tb_bcd_counter_n.sv
// Self-checking bench for bcd_counter_n with DIGITS=4. A saturating and a
// wrapping instance share stimulus; a decimal integer model predicts both,
// pushing expectations to a queue that is popped after each clock edge.
module tb_bcd_counter_n;

    localparam int DIGITS = 4;

    logic        clk_used = 1'b0;
    logic        rst = 1'b0;
    logic        clr = 1'b0;
    logic        load = 1'b0;
    logic [15:0] load_val = 16'h0000;
    logic        run = 1'b0;
    logic        tick = 1'b0;
    logic        dir = 1'b1;
    logic [15:0] match_val = 16'h0000;

    logic [15:0] count0, count1;
    logic        at_max0, at_max1, at_min0, at_min1, tc0, tc1;
`ifdef BCD_COUNTER_MATCH_EN
    logic        match0, match1;
`endif

    always #5 clk_used = ~clk_used;

    bcd_counter_n #(.DIGITS(DIGITS), .WRAP(0)) u_dut_sat (
        .clk_used (clk_used),
        .rst      (rst),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .run      (run),
        .tick     (tick),
        .dir      (dir),
`ifdef BCD_COUNTER_MATCH_EN
        .match_val(match_val),
        .match    (match0),
`endif
        .count    (count0),
        .at_max   (at_max0),
        .at_min   (at_min0),
        .tc       (tc0)
    );

    bcd_counter_n #(.DIGITS(DIGITS), .WRAP(1)) u_dut_wrap (
        .clk_used (clk_used),
        .rst      (rst),
        .clr      (clr),
        .load     (load),
        .load_val (load_val),
        .run      (run),
        .tick     (tick),
        .dir      (dir),
`ifdef BCD_COUNTER_MATCH_EN
        .match_val(match_val),
        .match    (match1),
`endif
        .count    (count1),
        .at_max   (at_max1),
        .at_min   (at_min1),
        .tc       (tc1)
    );

    typedef struct {
        int   val0;
        int   val1;
        logic tc0;
        logic tc1;
        logic m0;
        logic m1;
    } exp_t;

    exp_t sb_q[$];
    int   m_val[2];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        int          x;
        x = v;
        r = 16'h0000;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int clamp_val(input logic [15:0] lv);
        int s;
        int p;
        int nib;
        s = 0;
        p = 1;
        for (int i = 0; i < DIGITS; i++) begin
            nib = int'(lv[4*i +: 4]);
            if (nib > 9) nib = 9;
            s = s + nib * p;
            p = p * 10;
        end
        return s;
    endfunction

    // Drive one cycle of stimulus, predict, then compare after the edge.
    task automatic cycle(input logic i_rst, input logic i_clr, input logic i_load,
                         input logic [15:0] i_lv, input logic i_run, input logic i_tick,
                         input logic i_dir);
        exp_t e;
        exp_t g;
        int   nv;
        logic t;
        logic upd;
        logic mt;
        rst = i_rst; clr = i_clr; load = i_load; load_val = i_lv;
        run = i_run; tick = i_tick; dir = i_dir;
        for (int w = 0; w < 2; w++) begin
            nv  = m_val[w];
            t   = 1'b0;
            upd = 1'b0;
            if (!i_rst || i_clr) begin
                nv = 0;
            end else if (i_load) begin
                nv  = clamp_val(i_lv);
                upd = 1'b1;
            end else if (i_run && i_tick) begin
                upd = 1'b1;
                if (i_dir) begin
                    if (nv == 9999) begin t = 1'b1; nv = (w == 1) ? 0 : 9999; end
                    else nv = nv + 1;
                end else begin
                    if (nv == 0) begin t = 1'b1; nv = (w == 1) ? 9999 : 0; end
                    else nv = nv - 1;
                end
            end
            mt = i_rst && upd && (to_bcd(nv) == match_val);
            m_val[w] = nv;
            if (w == 0) begin e.val0 = nv; e.tc0 = t; e.m0 = mt; end
            else        begin e.val1 = nv; e.tc1 = t; e.m1 = mt; end
        end
        sb_q.push_back(e);
        @(posedge clk_used);
        #1;
        g = sb_q.pop_front();
        check("sat_count", 32'(count0), 32'(to_bcd(g.val0)));
        check("sat_tc", 32'(tc0), 32'(g.tc0));
        check("sat_at_max", 32'(at_max0), 32'(g.val0 == 9999));
        check("sat_at_min", 32'(at_min0), 32'(g.val0 == 0));
        check("wrap_count", 32'(count1), 32'(to_bcd(g.val1)));
        check("wrap_tc", 32'(tc1), 32'(g.tc1));
        check("wrap_at_max", 32'(at_max1), 32'(g.val1 == 9999));
        check("wrap_at_min", 32'(at_min1), 32'(g.val1 == 0));
`ifdef BCD_COUNTER_MATCH_EN
        check("sat_match", 32'(match0), 32'(g.m0));
        check("wrap_match", 32'(match1), 32'(g.m1));
`endif
        @(negedge clk_used);
    endtask

    logic [15:0] lv_pick;

    initial begin
        m_val[0] = 0;
        m_val[1] = 0;
        @(negedge clk_used);

        // Reset held two cycles with tick active
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        check("reset_count_const", 32'(count0), 32'h0000_0000);

        // Up ripple 0999 -> 1000
        cycle(1'b1, 1'b0, 1'b1, 16'h0999, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        check("ripple_const", 32'(count0), 32'h0000_1000);

        // Terminal up then down step
        cycle(1'b1, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        check("sat_hold_const", 32'(count0), 32'h0000_9999);
        check("wrap_up_const", 32'(count1), 32'h0000_0000);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("sat_down_const", 32'(count0), 32'h0000_9998);

        // Terminal down then up from zero, plus idle cycle (tc must drop)
        cycle(1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0);
        check("wrap_down_const", 32'(count1), 32'h0000_9999);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);

        // Clamp and load-over-tick priority, then clr over load
        cycle(1'b1, 1'b0, 1'b1, 16'hF3A0, 1'b1, 1'b1, 1'b1);
        check("clamp_const", 32'(count0), 32'h0000_9390);
        cycle(1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 1'b1, 1'b1);

        // Compare match from 0003 up to 0005, then idle with run low
        match_val = 16'h0005;
        cycle(1'b1, 1'b0, 1'b1, 16'h0003, 1'b1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        cycle(1'b1, 1'b0, 1'b1, 16'h0004, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1'b1);

        // Reset mid-count with a pending tc
        cycle(1'b1, 1'b0, 1'b1, 16'h9999, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);

        // Randomised mix including back-to-back ticks and boundary presets
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 3))
                0:       lv_pick = 16'h9999;
                1:       lv_pick = 16'h0000;
                2:       lv_pick = 16'h9998;
                default: lv_pick = 16'($urandom);
            endcase
            if ((i % 25) == 0) match_val = to_bcd(int'($urandom_range(0, 9999)) % 10 + 9990 * int'($urandom_range(0, 1)));
            cycle(($urandom_range(0, 49) != 0), ($urandom_range(0, 29) == 0),
                  ($urandom_range(0, 9) == 0), lv_pick, ($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_bcd_counter_n
